// File: rtl/axilite_reg_slave.sv
// AXI-Lite slave register file: buffered AW/W beats commit byte-strobed writes,
// AR reads return one cycle later; one outstanding B and one outstanding R.
module axilite_reg_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [15:0]             wr_count
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int B      = $clog2(STRB_W);
    localparam int IW     = $clog2(NUM_REGS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte-offset bits are dropped; anything above the register index is out of range.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> (B + IW)) == '0;
    endfunction

    function automatic logic [IW-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[B +: IW];
    endfunction

    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]     w_strb;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic commit;

    assign s_axi_awready = ~aw_held;
    assign s_axi_wready  = ~w_held;
    assign s_axi_arready = ~s_axi_rvalid;

    assign aw_hs  = s_axi_awvalid & ~aw_held;
    assign w_hs   = s_axi_wvalid & ~w_held;
    assign ar_hs  = s_axi_arvalid & ~s_axi_rvalid;
    assign commit = aw_held & w_held & ~s_axi_bvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_addr <= s_axi_awaddr;
            end else if (commit) begin
                aw_held <= 1'b0;
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end else if (commit) begin
                w_held <= 1'b0;
            end
        end
    end

    // A new B is only raised once the previous one has been accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
            wr_count     <= '0;
        end else if (commit) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= addr_in_range(aw_addr) ? RESP_OKAY : RESP_SLVERR;
            wr_count     <= wr_count + 16'd1;
        end else if (s_axi_bvalid && s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit && addr_in_range(aw_addr)) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (w_strb[i]) begin
                    regs[addr_idx(aw_addr)][8*i +: 8] <= w_data[8*i +: 8];
                end
            end
        end
    end

    // The read samples the register file before a same-edge commit lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= addr_in_range(s_axi_araddr) ? regs[addr_idx(s_axi_araddr)] : '0;
            s_axi_rresp  <= addr_in_range(s_axi_araddr) ? RESP_OKAY : RESP_SLVERR;
        end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axilite_reg_slave.sv
// Directed bench for axilite_reg_slave: a reference register model feeds
// expected B/R responses into queues that are popped as the DUT responds.
module tb_axilite_reg_slave;

    logic        clk;
    logic        rst_n;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [15:0] wr_count;

    axilite_reg_slave #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(64),
        .NUM_REGS  (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axi_awaddr (awaddr),
        .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata  (wdata),
        .s_axi_wstrb  (wstrb),
        .s_axi_wvalid (wvalid),
        .s_axi_wready (wready),
        .s_axi_bresp  (bresp),
        .s_axi_bvalid (bvalid),
        .s_axi_bready (bready),
        .s_axi_araddr (araddr),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rdata  (rdata),
        .s_axi_rresp  (rresp),
        .s_axi_rvalid (rvalid),
        .s_axi_rready (rready),
        .wr_count     (wr_count)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    logic [1:0]  exp_b[$];
    r_exp_t      exp_r[$];
    logic [63:0] model [16];
    logic [15:0] exp_count;
    int          tests_run;
    int          tests_failed;
    int          lat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return a < 32'd128;
    endfunction

    function automatic int reg_of(input logic [31:0] a);
        return int'((a / 32'd8) % 32'd16);
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        if (in_range(a)) begin
            for (int b = 0; b < 8; b++) begin
                if (s[b]) model[reg_of(a)][8*b +: 8] = d[8*b +: 8];
            end
            exp_b.push_back(2'b00);
        end else begin
            exp_b.push_back(2'b10);
        end
        exp_count = exp_count + 16'd1;
    endfunction

    // Drives AW and W together, holding each valid until its own handshake.
    task automatic applyStimulus(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        bit aw_pend, w_pend, aw_fire, w_fire;
        int n;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        model_write(a, d, s);
        aw_pend = 1'b1; w_pend = 1'b1;
        for (n = 0; (aw_pend || w_pend) && n < 20; n++) begin
            aw_fire = aw_pend && awready;
            w_fire  = w_pend && wready;
            @(negedge clk);
            if (aw_fire) begin aw_pend = 1'b0; awvalid = 1'b0; end
            if (w_fire)  begin w_pend = 1'b0;  wvalid = 1'b0;  end
        end
        if (aw_pend || w_pend) checkOutput("aw_w_accept", 64'({aw_pend, w_pend}), 64'd0);
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic applyRead(input logic [31:0] a);
        r_exp_t e;
        bit fire, pend;
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        e.data = in_range(a) ? model[reg_of(a)] : 64'd0;
        e.resp = in_range(a) ? 2'b00 : 2'b10;
        exp_r.push_back(e);
        pend = 1'b1;
        for (n = 0; pend && n < 20; n++) begin
            fire = arready;
            @(negedge clk);
            if (fire) begin pend = 1'b0; arvalid = 1'b0; end
        end
        if (pend) checkOutput("ar_accept", 64'(arready), 64'd1);
        arvalid = 1'b0;
    endtask

    // Waits for bvalid, checks against the scoreboard, then lets the B handshake complete.
    task automatic waitWriteResp(output int n);
        logic [1:0] e;
        for (n = 0; !bvalid && n < 20; n++) @(negedge clk);
        if (!bvalid) begin
            checkOutput("b_timeout", 64'(bvalid), 64'd1);
        end else begin
            e = exp_b.pop_front();
            checkOutput("bresp", 64'(bresp), 64'(e));
            @(negedge clk);
        end
    endtask

    task automatic waitReadResp(output int n);
        r_exp_t e;
        for (n = 0; !rvalid && n < 20; n++) @(negedge clk);
        if (!rvalid) begin
            checkOutput("r_timeout", 64'(rvalid), 64'd1);
        end else begin
            e = exp_r.pop_front();
            checkOutput("rdata", rdata, e.data);
            checkOutput("rresp", 64'(rresp), 64'(e.resp));
            @(negedge clk);
        end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0; exp_count = 16'd0;
        for (int i = 0; i < 16; i++) model[i] = 64'd0;
        rst_n = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_awready", 64'(awready), 64'd1);
        checkOutput("rst_wready", 64'(wready), 64'd1);
        checkOutput("rst_arready", 64'(arready), 64'd1);
        checkOutput("rst_bvalid", 64'(bvalid), 64'd0);
        checkOutput("rst_rvalid", 64'(rvalid), 64'd0);
        checkOutput("rst_wr_count", 64'(wr_count), 64'd0);

        // Same-cycle AW+W, then read back with one-cycle latency.
        applyStimulus(32'h18, 64'h0000_0000_DEAD_BEEF, 8'hFF);
        waitWriteResp(lat);
        checkOutput("t1_b_latency", 64'(lat), 64'd1);
        checkOutput("t1_wr_count", 64'(wr_count), 64'(exp_count));
        applyRead(32'h18);
        waitReadResp(lat);
        checkOutput("t1_r_latency", 64'(lat), 64'd0);

        // W leads AW by three cycles.
        @(negedge clk);
        wdata = 64'h0123_4567_89AB_CDEF; wstrb = 8'hFF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        checkOutput("t2_wready_low", 64'(wready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t2_no_early_b", 64'(bvalid), 64'd0);
        awaddr = 32'h08; awvalid = 1'b1;
        model_write(32'h08, 64'h0123_4567_89AB_CDEF, 8'hFF);
        @(negedge clk);
        awvalid = 1'b0;
        waitWriteResp(lat);
        checkOutput("t2_b_latency", 64'(lat), 64'd1);
        repeat (3) @(negedge clk);
        checkOutput("t2_single_b", 64'(bvalid), 64'd0);
        checkOutput("t2_wr_count", 64'(wr_count), 64'(exp_count));
        applyRead(32'h08);
        waitReadResp(lat);

        // Partial byte strobe.
        applyStimulus(32'h10, 64'h1111_1111_1111_1111, 8'hFF);
        waitWriteResp(lat);
        applyStimulus(32'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        waitWriteResp(lat);
        applyRead(32'h10);
        waitReadResp(lat);

        // Out-of-range write/read alias onto reg 0 if decode ignores upper bits.
        applyStimulus(32'h80, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF);
        waitWriteResp(lat);
        applyRead(32'h80);
        waitReadResp(lat);
        applyRead(32'h00);
        waitReadResp(lat);
        checkOutput("t4_wr_count", 64'(wr_count), 64'(exp_count));

        // B backpressure with a second write queued behind it.
        bready = 1'b0;
        applyStimulus(32'h20, 64'h4444_0000_4444_0000, 8'hFF);
        applyStimulus(32'h28, 64'h5555_0000_5555_0000, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t5_bvalid_hold", 64'(bvalid), 64'd1);
        end
        checkOutput("t5_bresp_hold", 64'(bresp), 64'd0);
        checkOutput("t5_aw_held", 64'(awready), 64'd0);
        checkOutput("t5_one_commit", 64'(wr_count), 64'(exp_count - 16'd1));
        bready = 1'b1;
        waitWriteResp(lat);
        waitWriteResp(lat);
        checkOutput("t5_second_b_within_2", 64'(lat <= 2), 64'd1);
        checkOutput("t5_wr_count", 64'(wr_count), 64'(exp_count));
        applyRead(32'h20);
        waitReadResp(lat);
        applyRead(32'h28);
        waitReadResp(lat);

        // Reset while both responses are pending.
        bready = 1'b0; rready = 1'b0;
        applyStimulus(32'h38, 64'h7777_7777_7777_7777, 8'hFF);
        applyRead(32'h18);
        checkOutput("t6_bvalid_pending", 64'(bvalid), 64'd1);
        checkOutput("t6_rvalid_pending", 64'(rvalid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_bvalid_async", 64'(bvalid), 64'd0);
        checkOutput("t6_rvalid_async", 64'(rvalid), 64'd0);
        checkOutput("t6_rdata_async", rdata, 64'd0);
        exp_b.delete();
        exp_r.delete();
        for (int i = 0; i < 16; i++) model[i] = 64'd0;
        exp_count = 16'd0;
        @(negedge clk);
        rst_n = 1'b1; bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        checkOutput("t6_awready", 64'(awready), 64'd1);
        checkOutput("t6_arready", 64'(arready), 64'd1);
        checkOutput("t6_wr_count", 64'(wr_count), 64'd0);
        for (int i = 0; i < 16; i++) begin
            applyRead(32'(i * 8));
            waitReadResp(lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
